// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC sample scheduler: state encoding, converter
// width and accumulator sizing.
package adc_sched_pkg;

  localparam int ADC_WIDTH = 12;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_WAIT_LO = 3'd2;
  localparam state_t ST_ACCUM   = 3'd3;
  localparam state_t ST_PUBLISH = 3'd4;

  // Summing 2^avg_log2 full-scale samples needs avg_log2 extra bits of headroom.
  function automatic int acc_width(input int avg_log2);
    return ADC_WIDTH + avg_log2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into the local clock.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability-settling pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc_sample_scheduler.sv
// Periodically requests dual ADC conversions, averages 2^AVG_LOG2 of them per
// channel and publishes the result, with overrun and timeout supervision.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 50000,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                 CLOCK_50MHz,
  input  logic                 RESET_n,
  input  logic                 ENABLE,
  output logic                 ADC_START,
  input  logic                 ADC_BUSY,
  input  logic [ADC_WIDTH-1:0] ADC_DATA0,
  input  logic [ADC_WIDTH-1:0] ADC_DATA1,
  output logic [ADC_WIDTH-1:0] PADDLE0,
  output logic [ADC_WIDTH-1:0] PADDLE1,
  output logic                 VALID,
  output logic                 TIMEOUT_ERR,
  output logic                 OVERRUN
);

  localparam int ACC_W = acc_width(AVG_LOG2);
  localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

  logic                 busy_s;
  logic                 tick_s;
  logic [PER_W-1:0]     per_q, per_d;
  state_t               state_q, state_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [ACC_W-1:0]     acc0_q, acc0_d, acc1_q, acc1_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic                 valid_q, valid_d;
  logic [ADC_WIDTH-1:0] pad0_q, pad0_d, pad1_q, pad1_d;
  logic                 terr_q, terr_d;
  logic                 ovr_q, ovr_d;

  sync_2ff u_busy_sync (
    .clk_i  (CLOCK_50MHz),
    .rst_ni (RESET_n),
    .d_i    (ADC_BUSY),
    .q_o    (busy_s)
  );

  // Sampling period counter; parked at zero while disabled.
  always_comb begin
    tick_s = ENABLE && (per_q == PER_LAST);
    if (!ENABLE || (per_q == PER_LAST)) begin
      per_d = '0;
    end else begin
      per_d = per_q + PER_W'(1);
    end
  end

  // Conversion sequencing, averaging and error flags.
  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    pad0_d  = pad0_q;
    pad1_d  = pad1_q;
    terr_d  = terr_q;
    ovr_d   = ovr_q;

    if (!ENABLE) begin
      state_d = ST_IDLE;
      to_d    = '0;
      acc0_d  = '0;
      acc1_d  = '0;
      cnt_d   = '0;
      terr_d  = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (tick_s && (state_q != ST_IDLE)) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end

      case (state_q)
        ST_IDLE: begin
          to_d = '0;
          if (tick_s) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ, ST_WAIT_LO: begin
          to_d = to_q + TO_W'(1);
          // The timeout covers the whole request/conversion window.
          if (to_q == TO_LAST) begin
            terr_d  = 1'b1;
            acc0_d  = '0;
            acc1_d  = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if ((state_q == ST_REQ) && busy_s) begin
            state_d = ST_WAIT_LO;
          end else if ((state_q == ST_WAIT_LO) && !busy_s) begin
            state_d = ST_ACCUM;
          end else begin
            state_d = state_q;
          end
        end
        ST_ACCUM: begin
          acc0_d = acc0_q + ACC_W'(ADC_DATA0);
          acc1_d = acc1_q + ACC_W'(ADC_DATA1);
          cnt_d  = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1)) == CNT_FULL) begin
            state_d = ST_PUBLISH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PUBLISH: begin
          pad0_d  = ADC_WIDTH'(acc0_q >> AVG_LOG2);
          pad1_d  = ADC_WIDTH'(acc1_q >> AVG_LOG2);
          valid_d = 1'b1;
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    start_d = (state_d == ST_REQ);
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50MHz or negedge RESET_n) begin
    if (!RESET_n) begin
      per_q   <= '0;
      state_q <= ST_IDLE;
      to_q    <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      pad0_q  <= '0;
      pad1_q  <= '0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      per_q   <= per_d;
      state_q <= state_d;
      to_q    <= to_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      valid_q <= valid_d;
      pad0_q  <= pad0_d;
      pad1_q  <= pad1_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ADC_START   = start_q;
  assign VALID       = valid_q;
  assign PADDLE0     = pad0_q;
  assign PADDLE1     = pad1_q;
  assign TIMEOUT_ERR = terr_q;
  assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: behavioural ADC front-end plus an averaging
// reference built from the samples the front-end actually delivered.
module tb_adc_sample_scheduler;

  localparam int P = 100;
  localparam int A = 2;
  localparam int T = 400;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        busy;
  logic [11:0] d0, d1, p0, p1;
  logic        valid, terr, ovr;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_done  = 0;
  int n_valid = 0;
  int busy_len = 40;
  bit never_busy = 1'b0;
  int q0[$], q1[$], pend0[$], pend1[$];

  adc_sample_scheduler #(
    .PERIOD_CYCLES  (P),
    .AVG_LOG2       (A),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLOCK_50MHz (clk),
    .RESET_n     (rst_n),
    .ENABLE      (en),
    .ADC_START   (start),
    .ADC_BUSY    (busy),
    .ADC_DATA0   (d0),
    .ADC_DATA1   (d1),
    .PADDLE0     (p0),
    .PADDLE1     (p1),
    .VALID       (valid),
    .TIMEOUT_ERR (terr),
    .OVERRUN     (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Front-end: busy rises 3 cycles after a request, lasts busy_len cycles.
  initial begin : frontend
    bit ab;
    int v0, v1;
    busy = 1'b0;
    d0 = 12'd0;
    d1 = 12'd0;
    forever begin
      @(negedge clk);
      if (rst_n && en && start && !never_busy) begin
        ab = 1'b0;
        for (int i = 0; i < 3 && !ab; i++) begin
          @(negedge clk);
          if (!rst_n || !en) ab = 1'b1;
        end
        if (!ab) begin
          if (q0.size() > 0) v0 = q0.pop_front(); else v0 = int'($urandom_range(4095, 0));
          if (q1.size() > 0) v1 = q1.pop_front(); else v1 = int'($urandom_range(4095, 0));
          d0 = v0[11:0];
          d1 = v1[11:0];
          busy = 1'b1;
          for (int i = 0; i < busy_len && !ab; i++) begin
            @(negedge clk);
            if (!rst_n || !en) ab = 1'b1;
          end
          busy = 1'b0;
          if (!ab) begin
            pend0.push_back(v0);
            pend1.push_back(v1);
            n_done++;
          end
        end
      end
    end
  end

  // Reference: each VALID must carry the floor-average of the last 4 delivered samples.
  initial begin : monitor
    bit prev;
    int s0, s1;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        chk("valid_width", 32'(prev), 32'd0);
        if (pend0.size() < 4) begin
          chk("valid_early", 32'(pend0.size()), 32'd4);
        end else begin
          s0 = 0;
          s1 = 0;
          for (int k = 0; k < 4; k++) begin
            s0 += pend0.pop_front();
            s1 += pend1.pop_front();
          end
          chk("paddle0_avg", 32'(p0), 32'(s0 / 4));
          chk("paddle1_avg", 32'(p1), 32'(s1 / 4));
        end
        n_valid++;
      end
      prev = valid;
    end
  end

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (n_done < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("conv_count", 32'(n_done), 32'(target));
  endtask

  task automatic wait_valid(input int target, input int budget);
    int c = 0;
    while (n_valid < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("valid_count", 32'(n_valid), 32'(target));
  endtask

  task automatic cycles_to(input logic want, input int which, input int budget, output int cnt);
    logic s;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      s = (which == 0) ? start : terr;
    end while (s !== want && cnt < budget);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"}, 32'(start), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_pad0"},  32'(p0),    32'd0);
    chk({tag, "_pad1"},  32'(p1),    32'd0);
    chk({tag, "_terr"},  32'(terr),  32'd0);
    chk({tag, "_ovr"},   32'(ovr),   32'd0);
  endtask

  initial begin : main
    int c;
    int base;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Known-value group: 250 / 4095 and first-request latency.
    q0 = '{100, 200, 300, 400};
    q1 = '{4095, 4095, 4095, 4095};
    @(negedge clk);
    en = 1'b1;
    cycles_to(1'b1, 0, 300, c);
    chk("first_req_latency", 32'(c), 32'd100);
    wait_done(3, 400);
    repeat (10) @(negedge clk);
    chk("no_valid_after_3", 32'(n_valid), 32'd0);
    wait_done(4, 200);
    wait_valid(1, 50);
    chk("paddle0_250", 32'(p0), 32'd250);
    chk("paddle1_4095", 32'(p1), 32'd4095);

    // Truncating average.
    q0 = '{1, 1, 1, 2};
    q1 = '{0, 0, 0, 3};
    wait_valid(2, 600);
    chk("paddle0_trunc", 32'(p0), 32'd1);
    chk("paddle1_trunc", 32'(p1), 32'd0);

    // Random samples.
    wait_valid(5, 1500);
    chk("ovr_clean", 32'(ovr), 32'd0);
    chk("terr_clean", 32'(terr), 32'd0);

    // Long conversion straddles a tick: overrun, sample still averaged.
    busy_len = 150;
    base = n_done;
    wait_done(base + 1, 600);
    chk("overrun_set", 32'(ovr), 32'd1);
    busy_len = 40;
    wait_valid(6, 600);
    chk("overrun_sticky", 32'(ovr), 32'd1);

    // Disable after 2 conversions discards them and clears flags.
    base = n_done;
    wait_done(base + 2, 400);
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("dis_start", 32'(start), 32'd0);
    pend0.delete();
    pend1.delete();
    q0 = '{10, 20, 30, 40};
    q1 = '{4000, 4001, 4002, 4003};
    en = 1'b1;
    wait_valid(7, 700);
    chk("fresh_pad0", 32'(p0), 32'd25);
    chk("fresh_pad1", 32'(p1), 32'd4001);
    chk("fresh_terr", 32'(terr), 32'd0);
    chk("fresh_ovr", 32'(ovr), 32'd0);

    // Front-end never answers: timeout after T cycles, retry on next tick.
    never_busy = 1'b1;
    base = n_valid;
    cycles_to(1'b1, 0, 200, c);
    cycles_to(1'b1, 1, 600, c);
    chk("timeout_latency", 32'(c), 32'd400);
    chk("timeout_start_low", 32'(start), 32'd0);
    cycles_to(1'b1, 0, 200, c);
    chk("retry_latency", 32'(c), 32'd100);
    chk("timeout_no_valid", 32'(n_valid), 32'(base));
    chk("timeout_ovr", 32'(ovr), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("clr_terr", 32'(terr), 32'd0);
    chk("clr_ovr", 32'(ovr), 32'd0);
    chk("clr_start", 32'(start), 32'd0);
    never_busy = 1'b0;
    pend0.delete();
    pend1.delete();

    // Reset while waiting for busy to fall.
    en = 1'b1;
    cycles_to(1'b1, 0, 200, c);
    cycles_to(1'b0, 0, 50, c);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    pend0.delete();
    pend1.delete();
    rst_n = 1'b1;
    cycles_to(1'b1, 0, 200, c);
    chk("post_reset_latency", 32'(c), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
